// File: rtl/pht_update_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pht_update_scheduler                                          |
// | Purpose  : Owns the single port of the pattern history table SRAM       |
// |            (2-bit saturating counters). Shares the port between IF-stage |
// |            lookups and MEM-stage counter updates. Updates are computed  |
// |            on entry and buffered in a small FIFO. Lookups get the port  |
// |            unless the FIFO is full or its head has starved too long.    |
// | Ports    : clk, rst (async, active-low)                                  |
// |            if_req/if_idx -> if_stall, if_pred_valid, if_pred            |
// |            upd_valid/upd_idx/upd_taken/upd_pred -> upd_ready            |
// |            pht_en/pht_we/pht_addr/pht_wdata -> SRAM, pht_rdata <- SRAM  |
// | Options  : PHT_BYPASS_EN - forward pending FIFO counters to lookups     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pht_update_scheduler #(
  parameter int INDEX_W    = 8,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [INDEX_W-1:0] if_idx,
  output logic               if_stall,
  output logic               if_pred_valid,
  output logic [1:0]         if_pred,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic               upd_taken,
  input  logic [1:0]         upd_pred,
  output logic               upd_ready,
  output logic               pht_en,
  output logic               pht_we,
  output logic [INDEX_W-1:0] pht_addr,
  output logic [1:0]         pht_wdata,
  input  logic [1:0]         pht_rdata
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(QDEPTH);
  localparam logic [STV_W-1:0] STARVE_LIMIT = STV_W'(STARVE_MAX);

  // FIFO storage: index and already-updated counter value
  logic [INDEX_W-1:0] fifo_idx [QDEPTH];
  logic [1:0]         fifo_ctr [QDEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve;
  logic             pred_valid;

  logic       fifo_full;
  logic       fifo_empty;
  logic       forced;
  logic       grant_write;
  logic       grant_read;
  logic       enq;
  logic       deq;
  logic [1:0] new_ctr;

  // Saturating 2-bit counter step
  always_comb begin
    new_ctr = upd_pred;
    if (upd_taken) begin
      if (upd_pred != 2'b11) new_ctr = upd_pred + 2'b01;
    end else begin
      if (upd_pred != 2'b00) new_ctr = upd_pred - 2'b01;
    end
  end

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign upd_ready  = !fifo_full;
  assign enq        = upd_valid && upd_ready;

  // Grants are qualified with rst so the SRAM port stays quiet while
  // reset is asserted, even if IF keeps requesting.
  assign forced      = rst && !fifo_empty && (fifo_full || (starve == STARVE_LIMIT));
  assign grant_write = forced || (rst && !if_req && !fifo_empty);
  assign grant_read  = rst && if_req && !forced;
  assign deq         = grant_write;

  assign pht_en    = grant_write || grant_read;
  assign pht_we    = grant_write;
  assign pht_addr  = grant_write ? fifo_idx[rd_ptr] : if_idx;
  assign pht_wdata = fifo_ctr[rd_ptr];
  assign if_stall  = if_req && forced;

  assign if_pred_valid = pred_valid;

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_idx[wr_ptr] <= upd_idx;
      fifo_ctr[wr_ptr] <= new_ctr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve     <= '0;
      pred_valid <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Starve measures how long the current head has waited
      if (deq || fifo_empty) begin
        starve <= '0;
      end else if (starve != STARVE_LIMIT) begin
        starve <= starve + STV_W'(1);
      end
      pred_valid <= grant_read;
    end
  end

`ifdef PHT_BYPASS_EN
  logic [INDEX_W-1:0] resp_idx;
  logic [1:0]         byp_ctr;
  logic [PTR_W-1:0]   slot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_idx <= '0;
    end else if (grant_read) begin
      resp_idx <= if_idx;
    end
  end

  // Walk oldest to youngest so the last match (the youngest) wins.
  // Entries written in the response cycle are still present here.
  always_comb begin
    byp_ctr = pht_rdata;
    slot    = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      slot = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo_idx[slot] == resp_idx)) begin
        byp_ctr = fifo_ctr[slot];
      end
    end
  end

  assign if_pred = pred_valid ? byp_ctr : 2'b01;
`else
  assign if_pred = pred_valid ? pht_rdata : 2'b01;
`endif

endmodule
`default_nettype wire
